csr_bank: RTL and testbench

Parametrised control/status register bank that replaces the fixed-map GPIO/link register file behind the I2C slave. It provides a registered request/acknowledge bus port and a configurable array of read/write registers and read-only input windows. It also adds sticky event status with write-1-to-clear, an interrupt enable mask and IRQ output, and a saturating clear-on-read error counter. It sits between the I2C slave front end and the board hardware (LEDs, switches, SPI data plane).

---
 rtl/csr_pkg.sv | 21 ++
 rtl/csr_event_status.sv | 49 ++++
 rtl/csr_bank.sv | 180 ++++++++++++++++++
 tb/tb_csr_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the CSR bank: fixed register map,
// CTRL bit positions and the bus handshake state type.
package csr_pkg;

  localparam logic [7:0] ADDR_DEVICE_ID = 8'h00;
  localparam logic [7:0] ADDR_VER_MAJ   = 8'h01;
  localparam logic [7:0] ADDR_VER_MIN   = 8'h02;
  localparam logic [7:0] ADDR_IRQ_STAT  = 8'h03;
  localparam logic [7:0] ADDR_IRQ_EN    = 8'h04;
  localparam logic [7:0] ADDR_ERR_CNT   = 8'h05;
  localparam logic [7:0] ADDR_CTRL      = 8'h06;

  localparam int CTRL_SOFT_RST   = 0;
  localparam int CTRL_ERR_STICKY = 7;

  typedef enum logic {
    IDLE,
    ACK
  } bus_state_t;

endpackage

// File: rtl/csr_event_status.sv
// Sticky event status with write-1-to-clear, enable mask,
// registered interrupt and soft-reset clear.
module csr_event_status #(
  parameter int N_EVT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_EVT-1:0] evt_in,
  input  logic             w1c_we,
  input  logic [N_EVT-1:0] w1c_mask,
  input  logic             en_we,
  input  logic [N_EVT-1:0] en_wdata,
  input  logic             soft_clr,
  output logic [N_EVT-1:0] status,
  output logic [N_EVT-1:0] enable,
  output logic             irq
);

  logic [N_EVT-1:0] status_q, status_d;
  logic [N_EVT-1:0] enable_q, enable_d;
  logic             irq_q, irq_d;

  // Events are OR-ed in last so they beat both W1C and soft clear.
  always_comb begin
    status_d = status_q;
    if (soft_clr) status_d = '0;
    if (w1c_we) status_d = status_d & ~w1c_mask;
    status_d = status_d | evt_in;
    enable_d = en_we ? en_wdata : enable_q;
    irq_d    = |(status_q & enable_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
      enable_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      enable_q <= enable_d;
      irq_q    <= irq_d;
    end
  end

  assign status = status_q;
  assign enable = enable_q;
  assign irq    = irq_q;

endmodule

// File: rtl/csr_bank.sv
// Parametrised CSR bank: req/ack bus port, R/W array, RO
// windows, event status/IRQ and clear-on-read error counter.
module csr_bank
  import csr_pkg::*;
#(
  parameter int              ADDR_W    = 8,
  parameter int              DATA_W    = 8,
  parameter int              NUM_RW    = 16,
  parameter int              NUM_RO    = 8,
  parameter int              N_EVT     = 8,
  parameter logic [ADDR_W-1:0] RW_BASE = 8'h10,
  parameter logic [ADDR_W-1:0] RO_BASE = 8'h40,
  parameter logic [7:0]      DEVICE_ID = 8'hA7,
  parameter logic [15:0]     VERSION   = 16'h0200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bus_req,
  input  logic                     bus_we,
  input  logic [ADDR_W-1:0]        bus_addr,
  input  logic [DATA_W-1:0]        bus_wdata,
  output logic                     bus_ack,
  output logic [DATA_W-1:0]        bus_rdata,
  output logic                     bus_err,
  output logic [NUM_RW*DATA_W-1:0] rw_q,
  input  logic [NUM_RO*DATA_W-1:0] ro_d,
  input  logic [N_EVT-1:0]         evt_in,
  input  logic                     err_pulse,
  output logic                     irq,
  output logic                     soft_rst
);

  bus_state_t state_q, state_d;
  logic       armed_q, armed_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic [NUM_RW*DATA_W-1:0] rw_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic       sticky_q, sticky_d;
  logic       soft_q, soft_d;

  logic [NUM_RW-1:0] rw_hit;
  logic [DATA_W-1:0] rw_rd, ro_rd, rd_val;
  logic       hit_ro, unmapped, access;
  logic       w1c_we, en_we, rd_cnt;
  logic [N_EVT-1:0] status, enable;

  always_comb begin
    rw_hit   = '0;
    rw_rd    = '0;
    ro_rd    = '0;
    hit_ro   = 1'b0;
    rd_val   = '0;
    unmapped = 1'b0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (bus_addr == ADDR_W'(RW_BASE + i)) begin
        rw_hit[i] = 1'b1;
        rw_rd     = rw_q[i*DATA_W +: DATA_W];
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (bus_addr == ADDR_W'(RO_BASE + j)) begin
        hit_ro = 1'b1;
        ro_rd  = ro_d[j*DATA_W +: DATA_W];
      end
    end
    unique case (1'b1)
      bus_addr == ADDR_W'(ADDR_DEVICE_ID):
        rd_val = DATA_W'(DEVICE_ID);
      bus_addr == ADDR_W'(ADDR_VER_MAJ):
        rd_val = DATA_W'(VERSION[15:8]);
      bus_addr == ADDR_W'(ADDR_VER_MIN):
        rd_val = DATA_W'(VERSION[7:0]);
      bus_addr == ADDR_W'(ADDR_IRQ_STAT):
        rd_val = DATA_W'(status);
      bus_addr == ADDR_W'(ADDR_IRQ_EN):
        rd_val = DATA_W'(enable);
      bus_addr == ADDR_W'(ADDR_ERR_CNT):
        rd_val = cnt_q;
      bus_addr == ADDR_W'(ADDR_CTRL):
        rd_val[CTRL_ERR_STICKY] = sticky_q;
      |rw_hit: rd_val = rw_rd;
      hit_ro:  rd_val = ro_rd;
      default: unmapped = 1'b1;
    endcase
  end

  // A held request must be seen low once before it can re-arm.
  assign access = (state_q == IDLE) && bus_req && armed_q;

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rw_d     = rw_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    soft_d   = 1'b0;
    w1c_we   = 1'b0;
    en_we    = 1'b0;
    rd_cnt   = 1'b0;
    case (state_q)
      IDLE:    if (access) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (soft_q) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (access) begin
      armed_d = 1'b0;
      rdata_d = rd_val;
      err_d   = unmapped;
      if (unmapped) sticky_d = 1'b1;
      if (bus_we) begin
        for (int i = 0; i < NUM_RW; i++) begin
          if (rw_hit[i]) rw_d[i*DATA_W +: DATA_W] = bus_wdata;
        end
        if (bus_addr == ADDR_W'(ADDR_IRQ_STAT)) w1c_we = 1'b1;
        if (bus_addr == ADDR_W'(ADDR_IRQ_EN)) en_we = 1'b1;
        if (bus_addr == ADDR_W'(ADDR_CTRL)) begin
          soft_d = bus_wdata[CTRL_SOFT_RST];
          if (bus_wdata[CTRL_ERR_STICKY]) sticky_d = 1'b0;
        end
      end else if (bus_addr == ADDR_W'(ADDR_ERR_CNT)) begin
        rd_cnt = 1'b1;
      end
    end else if (!bus_req) begin
      armed_d = 1'b1;
    end
    if (rd_cnt) cnt_d = '0;
    if (err_pulse && (cnt_d != '1)) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      armed_q  <= 1'b1;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      rw_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      soft_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      rw_q     <= rw_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      soft_q   <= soft_d;
    end
  end

  csr_event_status #(
    .N_EVT(N_EVT)
  ) u_evt (
    .clk     (clk),
    .rst_n   (rst_n),
    .evt_in  (evt_in),
    .w1c_we  (w1c_we),
    .w1c_mask(bus_wdata[N_EVT-1:0]),
    .en_we   (en_we),
    .en_wdata(bus_wdata[N_EVT-1:0]),
    .soft_clr(soft_q),
    .status  (status),
    .enable  (enable),
    .irq     (irq)
  );

  assign bus_ack   = (state_q == ACK);
  assign bus_rdata = rdata_q;
  assign bus_err   = err_q & bus_ack;
  assign soft_rst  = soft_q;

endmodule

// File: tb/tb_csr_bank.sv
// Randomized bench for csr_bank against a register-map
// reference model, plus directed literal checks.
module tb_csr_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         bus_req = 1'b0;
  logic         bus_we = 1'b0;
  logic [7:0]   bus_addr = '0;
  logic [7:0]   bus_wdata = '0;
  logic         bus_ack;
  logic [7:0]   bus_rdata;
  logic         bus_err;
  logic [127:0] rw_q;
  logic [63:0]  ro_d = '0;
  logic [7:0]   evt_in = '0;
  logic         err_pulse = 1'b0;
  logic         irq;
  logic         soft_rst;

  int vectors = 0;
  int miscompares = 0;
  bit bg = 1'b0;

  csr_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata),
    .bus_err  (bus_err),
    .rw_q     (rw_q),
    .ro_d     (ro_d),
    .evt_in   (evt_in),
    .err_pulse(err_pulse),
    .irq      (irq),
    .soft_rst (soft_rst)
  );

  // Reference model state
  logic [127:0] m_rw;
  logic [7:0]   m_st, m_en, m_cnt, m_rdata;
  bit m_sticky, m_ack, m_soft, m_irq, m_err, m_armed;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rw = '0; m_st = 0; m_en = 0; m_cnt = 0;
    m_rdata = 0; m_sticky = 0; m_ack = 0;
    m_soft = 0; m_irq = 0; m_err = 0; m_armed = 1;
  endtask

  task automatic model_step();
    logic [7:0] st, cnt, rd;
    bit sticky, er, acc;
    int a;
    a = int'(bus_addr);
    acc = bus_req && !m_ack && m_armed;
    st = m_soft ? 8'h00 : m_st;
    cnt = m_soft ? 8'h00 : m_cnt;
    sticky = m_soft ? 1'b0 : m_sticky;
    rd = 0;
    er = 0;
    m_irq = |(m_st & m_en);
    if (acc) begin
      if (a == 0) rd = 8'hA7;
      else if (a == 1) rd = 8'h02;
      else if (a == 2) rd = 8'h00;
      else if (a == 3) rd = m_st;
      else if (a == 4) rd = m_en;
      else if (a == 5) rd = m_cnt;
      else if (a == 6) rd = {m_sticky, 7'b0};
      else if (a >= 16 && a < 32) rd = m_rw[(a-16)*8 +: 8];
      else if (a >= 64 && a < 72) rd = ro_d[(a-64)*8 +: 8];
      else begin er = 1; sticky = 1; end
      if (bus_we) begin
        if (a >= 16 && a < 32) m_rw[(a-16)*8 +: 8] = bus_wdata;
        if (a == 3) st = st & ~bus_wdata;
        if (a == 4) m_en = bus_wdata;
        if (a == 6 && bus_wdata[7]) sticky = 0;
      end else if (a == 5) begin
        cnt = 0;
      end
      m_rdata = rd;
      m_err = er;
    end
    if (err_pulse && cnt != 8'hFF) cnt = cnt + 8'd1;
    m_st = st | evt_in;
    m_cnt = cnt;
    m_sticky = sticky;
    m_soft = acc && bus_we && a == 6 && bus_wdata[0];
    if (acc) m_armed = 0;
    else if (!bus_req) m_armed = 1;
    m_ack = acc;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #2;
    if (bg) begin
      evt_in = 8'($urandom);
      err_pulse = ($urandom_range(0, 3) == 0);
      ro_d = {$urandom, $urandom};
    end
  endtask

  always @(negedge clk) begin
    chk("ack", bus_ack, m_ack);
    chk("irq", irq, m_irq);
    chk("soft_rst", soft_rst, m_soft);
    chk("rw_q", rw_q, m_rw);
    chk("rdata", bus_rdata, m_rdata);
    if (m_ack) chk("err", bus_err, m_err);
  end

  task automatic acc(input bit we, input logic [7:0] a,
                     input logic [7:0] d, input logic [7:0] ev,
                     input bit ep, input int hold,
                     output logic [7:0] rd, output bit er);
    tick();
    bus_req = 1; bus_we = we; bus_addr = a; bus_wdata = d;
    if (!bg) begin evt_in = ev; err_pulse = ep; end
    tick();
    chk("ack_lat", bus_ack, 1);
    rd = bus_rdata;
    er = bus_err;
    if (!bg) begin evt_in = 0; err_pulse = 0; end
    repeat (hold) tick();
    bus_req = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    bit e;
    acc(1, a, d, 0, 0, 0, r, e);
  endtask

  task automatic rd_chk(string nm, input logic [7:0] a,
                        input logic [7:0] exp, input bit exp_er);
    logic [7:0] r;
    bit e;
    acc(0, a, 0, 0, 0, 0, r, e);
    chk(nm, r, exp);
    chk({nm, "_err"}, e, exp_er);
  endtask

  initial begin
    logic [7:0] r;
    bit e;
    int n;
    model_reset();
    repeat (2) tick();
    chk("rst_ack", bus_ack, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rwq", rw_q, 0);
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_soft", soft_rst, 0);
    rst_n = 1;

    rd_chk("dev_id", 8'h00, 8'hA7, 0);
    rd_chk("ver_maj", 8'h01, 8'h02, 0);
    rd_chk("ver_min", 8'h02, 8'h00, 0);

    wr(8'h10, 8'h5A);
    wr(8'h1F, 8'hC3);
    rd_chk("rw10", 8'h10, 8'h5A, 0);
    rd_chk("rw1f", 8'h1F, 8'hC3, 0);
    chk("rwq0", rw_q[7:0], 8'h5A);
    wr(8'h30, 8'hFF);
    rd_chk("unmap", 8'h30, 8'h00, 1);
    rd_chk("ctrl_sticky", 8'h06, 8'h80, 0);
    wr(8'h06, 8'h80);
    rd_chk("ctrl_clr", 8'h06, 8'h00, 0);

    ro_d = 64'h0000_0000_3C00_0000;
    rd_chk("ro43", 8'h43, 8'h3C, 0);

    wr(8'h04, 8'h01);
    tick();
    evt_in = 8'h01;
    tick();
    evt_in = 8'h00;
    chk("irq_early", irq, 0);
    tick();
    chk("irq_rise", irq, 1);
    rd_chk("stat1", 8'h03, 8'h01, 0);
    acc(1, 8'h03, 8'h01, 8'h01, 0, 0, r, e);
    rd_chk("stat_setwins", 8'h03, 8'h01, 0);

    err_pulse = 1;
    repeat (300) tick();
    err_pulse = 0;
    rd_chk("cnt_sat", 8'h05, 8'hFF, 0);
    rd_chk("cnt_clr", 8'h05, 8'h00, 0);
    acc(0, 8'h05, 0, 0, 1, 0, r, e);
    chk("cnt_coinc", r, 8'h00);
    rd_chk("cnt_one", 8'h05, 8'h01, 0);

    err_pulse = 1;
    repeat (3) tick();
    err_pulse = 0;
    wr(8'h06, 8'h01);
    chk("soft_hi", soft_rst, 1);
    tick();
    chk("soft_lo", soft_rst, 0);
    rd_chk("soft_stat", 8'h03, 8'h00, 0);
    rd_chk("soft_cnt", 8'h05, 8'h00, 0);
    rd_chk("soft_en", 8'h04, 8'h01, 0);
    rd_chk("soft_rw", 8'h10, 8'h5A, 0);

    tick();
    bus_req = 1; bus_we = 0; bus_addr = 8'h00;
    n = 0;
    repeat (4) begin
      tick();
      if (bus_ack) n++;
    end
    bus_req = 0;
    chk("hold_acks", n, 1);

    tick();
    bus_req = 1; bus_we = 1; bus_addr = 8'h11; bus_wdata = 8'h99;
    tick();
    bus_req = 0;
    chk("pre_rst_ack", bus_ack, 1);
    #1;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_mid_ack", bus_ack, 0);
    tick();
    rst_n = 1;
    rd_chk("post_rst", 8'h00, 8'hA7, 0);
    rd_chk("post_rst_rw", 8'h11, 8'h00, 0);

    bg = 1;
    for (int k = 0; k < 600; k++) begin
      logic [7:0] a;
      int sel, hold;
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = 8'($urandom_range(0, 7));
        1, 2: a = 8'h10 + 8'($urandom_range(0, 15));
        3: a = 8'h40 + 8'($urandom_range(0, 7));
        4: a = 8'($urandom);
        default: a = 8'($urandom_range(3, 6));
      endcase
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      acc($urandom_range(0, 1) == 1, a, 8'($urandom),
          0, 0, hold, r, e);
      repeat ($urandom_range(0, 2)) tick();
    end
    bg = 0;
    evt_in = 0;
    err_pulse = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
